eth_link_bringup_ctrl: RTL and testbench

//  Sequences 10G link bring-up on the slowest clock: PLL reset -> PLL lock -> PCS reset -> block lock -> MAC release.

---
 rtl/eth_link_bringup_ctrl.sv | 144 ++++++++++++++
 tb/tb_eth_link_bringup_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_link_bringup_ctrl.sv
// eth_link_bringup_ctrl: sequences PLL -> PCS -> MAC reset release for a 10G link on the slowest clock.
// Latency: outputs are registered and change on the same edge as o_state; no backpressure (status/reset outputs only).
// ETH_BRINGUP_RETRY_LIMIT_EN: caps retries at MAX_RETRIES and enables the sticky FAIL state.
module eth_link_bringup_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_restart,
  input  logic       i_pll_locked,
  input  logic       i_block_lock,
  output logic       o_pll_reset,
  output logic       o_pcs_reset,
  output logic       o_mac_reset,
  output logic       o_link_up,
  output logic [2:0] o_state,
  output logic [7:0] o_retry_count,
  output logic       o_fail
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_RST   = 3'd1,
    PLL_WAIT  = 3'd2,
    PCS_RST   = 3'd3,
    LOCK_WAIT = 3'd4,
    LINK_UP   = 3'd5,
    FAIL      = 3'd6
  } state_t;

`ifdef ETH_BRINGUP_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  // One timer serves both the reset-hold and the lock-timeout windows.
  localparam int TMR_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int STB_W   = $clog2(STABLE_CYCLES) + 1;

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);

  state_t           state;
  state_t           nxt_state;
  logic [TMR_W-1:0] tmr;
  logic [STB_W-1:0] stb;
  logic             retry_evt;
  logic             move;
  logic             pll_lost;
  logic             limit_hit;
  logic             timed;

  assign o_state   = state;
  assign pll_lost  = !i_pll_locked && (state == PCS_RST || state == LOCK_WAIT || state == LINK_UP);
  assign limit_hit = LIMIT_EN && ({24'd0, o_retry_count} >= 32'(MAX_RETRIES));
  assign timed     = (state == PLL_RST) || (state == PLL_WAIT) || (state == PCS_RST) || (state == LOCK_WAIT);
  // A held restart re-enters PLL_RST every cycle, so it counts as a transition too.
  assign move      = i_restart || (nxt_state != state);

  always_comb begin
    nxt_state = state;
    retry_evt = 1'b0;
    if (i_restart) begin
      nxt_state = PLL_RST;
    end else if (pll_lost) begin
      nxt_state = PLL_RST;
      retry_evt = 1'b1;
    end else if (state == LINK_UP && !i_block_lock) begin
      nxt_state = PCS_RST;
      retry_evt = 1'b1;
    end else begin
      case (state)
        IDLE:     nxt_state = PLL_RST;
        PLL_RST:  if (tmr == RST_LAST) nxt_state = PLL_WAIT;
        PLL_WAIT: begin
          if (tmr == TO_LAST) begin
            nxt_state = PLL_RST;
            retry_evt = 1'b1;
          end else if (i_pll_locked) begin
            nxt_state = PCS_RST;
          end
        end
        PCS_RST:  if (tmr == RST_LAST) nxt_state = LOCK_WAIT;
        LOCK_WAIT: begin
          // Reaching the stable count beats a timeout landing on the same cycle.
          if (i_block_lock && stb == STB_LAST) begin
            nxt_state = LINK_UP;
          end else if (tmr == TO_LAST) begin
            nxt_state = PCS_RST;
            retry_evt = 1'b1;
          end
        end
        default:  nxt_state = state;
      endcase
    end
    if (retry_evt && limit_hit) nxt_state = FAIL;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      tmr           <= '0;
      stb           <= '0;
      o_retry_count <= '0;
      o_pll_reset   <= 1'b1;
      o_pcs_reset   <= 1'b1;
      o_mac_reset   <= 1'b1;
      o_link_up     <= 1'b0;
`ifdef ETH_BRINGUP_RETRY_LIMIT_EN
      o_fail        <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      tmr   <= (move || !timed) ? '0 : tmr + 1'b1;
      stb   <= (move || !i_block_lock || state != LOCK_WAIT) ? '0 : stb + 1'b1;

      if (i_restart || (nxt_state == LINK_UP && state != LINK_UP)) begin
        o_retry_count <= '0;
      end else if (retry_evt && !limit_hit && o_retry_count != 8'hFF) begin
        o_retry_count <= o_retry_count + 8'd1;
      end

      // Outputs decode the next state so they line up with o_state.
      o_pll_reset <= (nxt_state == IDLE) || (nxt_state == PLL_RST) || (nxt_state == FAIL);
      o_pcs_reset <= !((nxt_state == LOCK_WAIT) || (nxt_state == LINK_UP));
      o_mac_reset <= (nxt_state != LINK_UP);
      o_link_up   <= (nxt_state == LINK_UP);
`ifdef ETH_BRINGUP_RETRY_LIMIT_EN
      o_fail      <= (nxt_state == FAIL);
`endif
    end
  end

`ifndef ETH_BRINGUP_RETRY_LIMIT_EN
  assign o_fail = 1'b0;
`endif

endmodule

// File: tb/tb_eth_link_bringup_ctrl.sv
// Bench for eth_link_bringup_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRIES=2.
module tb_eth_link_bringup_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic       pll = 1'b0;
  logic       blk = 1'b0;
  logic       pll_r, pcs_r, mac_r, link_up, fail;
  logic [2:0] st;
  logic [7:0] rc;

  always #5 clk = ~clk;

  eth_link_bringup_ctrl #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(16), .STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_restart(restart), .i_pll_locked(pll), .i_block_lock(blk),
    .o_pll_reset(pll_r), .o_pcs_reset(pcs_r), .o_mac_reset(mac_r), .o_link_up(link_up),
    .o_state(st), .o_retry_count(rc), .o_fail(fail)
  );

  typedef struct packed { logic rst, restart, pll, blk; } in_t;
  typedef struct packed {
    logic pll_r, pcs_r, mac_r, link;
    logic [2:0] st;
    logic [7:0] rc;
    logic fail;
  } out_t;
  typedef struct { in_t i; int n; out_t o; string name; } vec_t;
  typedef struct { int cyc; out_t o; string name; } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   cyc_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Output levels per state, straight from the state table.
  function automatic out_t eo(int s, int r, bit f);
    out_t o;
    o.st    = 3'(s);
    o.rc    = 8'(r);
    o.fail  = f;
    o.pll_r = (s == 0) || (s == 1) || (s == 6);
    o.pcs_r = !((s == 4) || (s == 5));
    o.mac_r = (s != 5);
    o.link  = (s == 5);
    return o;
  endfunction

  // Hold inputs for n cycles, expect o after the n-th edge.
  function automatic vec_t mk(bit r, bit rs, bit p, bit b, int n, int s, int r_cnt, bit f, string nm);
    vec_t v;
    v.i    = {r, rs, p, b};
    v.n    = n;
    v.o    = eo(s, r_cnt, f);
    v.name = nm;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    sb_t e;
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      {rst, restart, pll, blk} = v.i;
      if (k == v.n - 1) begin
        e.cyc  = cyc_cnt + 1;
        e.o    = v.o;
        e.name = v.name;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic run_tbl();
    while (tbl.size() > 0) apply(tbl.pop_front());
  endtask

  initial begin : monitor
    sb_t  e;
    out_t g;
    forever begin
      @(posedge clk);
      cyc_cnt++;
      #1;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc_cnt) begin
        e = sbq.pop_front();
        g = {pll_r, pcs_r, mac_r, link_up, st, rc, fail};
        n_cmp++;
        if (g !== e.o) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got st=%0d rc=%0d pll_rst=%b pcs_rst=%b mac_rst=%b link=%b fail=%b, want st=%0d rc=%0d pll_rst=%b pcs_rst=%b mac_rst=%b link=%b fail=%b",
                   e.name, cyc_cnt, g.st, g.rc, g.pll_r, g.pcs_r, g.mac_r, g.link, g.fail,
                   e.o.st, e.o.rc, e.o.pll_r, e.o.pcs_r, e.o.mac_r, e.o.link, e.o.fail);
        end
      end
    end
  end

  initial begin
    // Reset, happy path, block-lock loss, PLL-lock loss, glitch with stable/timeout coincidence.
    tbl.push_back(mk(1,0,0,0, 2, 0,0,0, "reset_values"));
    tbl.push_back(mk(0,0,0,0, 1, 1,0,0, "idle_exit"));
    tbl.push_back(mk(0,0,0,0, 3, 1,0,0, "pll_rst_hold"));
    tbl.push_back(mk(0,0,0,0, 1, 2,0,0, "pll_reset_release"));
    tbl.push_back(mk(0,0,0,0, 3, 2,0,0, "pll_wait_nolock"));
    tbl.push_back(mk(0,0,1,0, 1, 3,0,0, "pll_lock_seen"));
    tbl.push_back(mk(0,0,1,0, 3, 3,0,0, "pcs_rst_hold"));
    tbl.push_back(mk(0,0,1,0, 1, 4,0,0, "pcs_reset_release"));
    tbl.push_back(mk(0,0,1,1, 7, 4,0,0, "stable_7_not_up"));
    tbl.push_back(mk(0,0,1,1, 1, 5,0,0, "link_up_after_8"));
    tbl.push_back(mk(0,0,1,1, 5, 5,0,0, "link_hold"));
    tbl.push_back(mk(0,0,1,0, 1, 3,1,0, "block_lock_loss"));
    tbl.push_back(mk(0,0,1,1, 3, 3,1,0, "pcs_rst_after_loss"));
    tbl.push_back(mk(0,0,1,1, 1, 4,1,0, "lock_wait_again"));
    tbl.push_back(mk(0,0,1,1, 7, 4,1,0, "restable_7"));
    tbl.push_back(mk(0,0,1,1, 1, 5,0,0, "relink_clears_retry"));
    tbl.push_back(mk(0,0,0,1, 1, 1,1,0, "pll_lock_loss"));
    tbl.push_back(mk(0,0,0,1, 3, 1,1,0, "pll_rst_after_loss"));
    tbl.push_back(mk(0,0,1,0, 1, 2,1,0, "pll_wait_reentry"));
    tbl.push_back(mk(0,0,1,0, 1, 3,1,0, "immediate_lock"));
    tbl.push_back(mk(0,0,1,0, 3, 3,1,0, "pcs_rst_hold2"));
    tbl.push_back(mk(0,0,1,0, 1, 4,1,0, "lock_wait_enter"));
    tbl.push_back(mk(0,0,1,1, 7, 4,1,0, "glitch_run1"));
    tbl.push_back(mk(0,0,1,0, 1, 4,1,0, "glitch_low"));
    tbl.push_back(mk(0,0,1,1, 7, 4,1,0, "glitch_run2_7"));
    tbl.push_back(mk(0,0,1,1, 1, 5,0,0, "stable_beats_timeout"));
    // PLL never locks: 4 + 16 cycle retry loop.
    tbl.push_back(mk(0,1,0,0, 1, 1,0,0, "restart_from_link"));
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(0,0,0,0, 3, 1,r,0, "pll_rst_loop"));
      tbl.push_back(mk(0,0,0,0, 1, 2,r,0, "pll_wait_loop"));
      tbl.push_back(mk(0,0,0,0, 15, 2,r,0, "pll_wait_15"));
      tbl.push_back(mk(0,0,0,0, 1, 1,r+1,0, "pll_timeout"));
    end
    tbl.push_back(mk(0,0,0,0, 3, 1,2,0, "pll_rst_loop3"));
    tbl.push_back(mk(0,0,0,0, 1, 2,2,0, "pll_wait_loop3"));
    tbl.push_back(mk(0,0,0,0, 15, 2,2,0, "pll_wait_15_3"));
`ifdef ETH_BRINGUP_RETRY_LIMIT_EN
    tbl.push_back(mk(0,0,0,0, 1, 6,2,1, "third_timeout_fail"));
    tbl.push_back(mk(0,0,1,1, 3, 6,2,1, "fail_sticky"));
`else
    tbl.push_back(mk(0,0,0,0, 1, 1,3,0, "third_timeout_retry"));
`endif
    tbl.push_back(mk(0,1,0,0, 3, 1,0,0, "restart_held"));
    tbl.push_back(mk(0,0,0,0, 3, 1,0,0, "after_restart_hold"));
    tbl.push_back(mk(0,0,0,0, 1, 2,0,0, "after_restart_wait"));
    // LOCK_WAIT timeouts up to retry=2, then restart.
    tbl.push_back(mk(0,0,1,0, 1, 3,0,0, "lw_pll_lock"));
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(0,0,1,0, 3, 3,r,0, "lw_pcs_rst"));
      tbl.push_back(mk(0,0,1,0, 1, 4,r,0, "lw_enter"));
      tbl.push_back(mk(0,0,1,0, 15, 4,r,0, "lw_no_timeout_yet"));
      tbl.push_back(mk(0,0,1,0, 1, 3,r+1,0, "lw_timeout"));
    end
    tbl.push_back(mk(0,0,1,0, 3, 3,2,0, "lw_pcs_rst3"));
    tbl.push_back(mk(0,0,1,0, 1, 4,2,0, "lw_retry2"));
    tbl.push_back(mk(0,1,1,0, 1, 1,0,0, "restart_in_lock_wait"));
    tbl.push_back(mk(0,0,1,0, 3, 1,0,0, "sat_pll_rst"));
    tbl.push_back(mk(0,0,1,0, 1, 2,0,0, "sat_pll_wait"));
    tbl.push_back(mk(0,0,1,0, 1, 3,0,0, "sat_start"));
    run_tbl();

    // Block lock never comes: one LOCK_WAIT timeout per 20 cycles.
`ifdef ETH_BRINGUP_RETRY_LIMIT_EN
    apply(mk(0,0,1,0, 20, 3,1,0, "retry_1"));
    apply(mk(0,0,1,0, 20, 3,2,0, "retry_2"));
    apply(mk(0,0,1,0, 20, 6,2,1, "limit_fail"));
    apply(mk(0,0,0,0, 5, 6,2,1, "fail_holds"));
`else
    for (int k = 1; k <= 257; k++) begin
      apply(mk(0,0,1,0, 20, 3, (k > 255) ? 255 : k, 0, "retry_saturate"));
    end
`endif

    // Reset wins over a coincident restart while the link is up.
    tbl.push_back(mk(0,1,1,1, 1, 1,0,0, "restart_clears"));
    tbl.push_back(mk(0,0,1,1, 3, 1,0,0, "r6_pll_rst"));
    tbl.push_back(mk(0,0,1,1, 1, 2,0,0, "r6_pll_wait"));
    tbl.push_back(mk(0,0,1,1, 1, 3,0,0, "r6_pcs_rst"));
    tbl.push_back(mk(0,0,1,1, 3, 3,0,0, "r6_pcs_hold"));
    tbl.push_back(mk(0,0,1,1, 1, 4,0,0, "r6_lock_wait"));
    tbl.push_back(mk(0,0,1,1, 7, 4,0,0, "r6_stable"));
    tbl.push_back(mk(0,0,1,1, 1, 5,0,0, "r6_link_up"));
    tbl.push_back(mk(1,1,1,1, 1, 0,0,0, "reset_over_restart"));
    tbl.push_back(mk(0,0,1,1, 1, 1,0,0, "post_reset_exit"));
    run_tbl();

    @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sbq.size());
      n_cmp += sbq.size();
      n_bad += sbq.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
